hmirror_line: RTL

// - Horizontal-mirror stage in the per-pixel processing chain; it sits directly upstream of the colour-negative stage and feeds it.
// - When enabled (image_mode 8'h02), each active line is output left-right reversed.
// - Mirroring uses ping-pong line RAMs: line N is written while line N-1 is read back reversed.
// - Net effect of mirroring: the image shifts down by one line, and the first active line of each frame is black.
// - Otherwise it is a pure 2-cycle pass-through.

---
 rtl/vpu_pkg.sv | 22 ++
 rtl/line_ram_sdp.sv | 28 ++
 rtl/hmirror_line.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// Shared definitions for the per-pixel video processing chain: image mode
// codes, pixel width and the bundled sync/enable type carried down the pipe.
package vpu_pkg;

   localparam logic [7:0] IMG_MODE_NEGATIVE = 8'h01;
   localparam logic [7:0] IMG_MODE_MIRROR   = 8'h02;
   localparam int         PIX_W             = 24;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef struct packed {
      logic vs;
      logic hs;
      logic de;
   } sync_t;

   // Packs separate colour channels into one RAM/pipeline word, red in the MSBs.
   function automatic pixel_t pack_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/line_ram_sdp.sv
// Simple dual-port line buffer: one write port, one registered read port,
// one clock of read latency. Written so synthesis maps it onto block RAM,
// which is why there is no reset on the array or the read register.
module line_ram_sdp
   import vpu_pkg::*;
#(
   parameter int DEPTH  = 1920,
   parameter int ADDR_W = 11
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  pixel_t            wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output pixel_t            rd_data
);

   pixel_t mem [DEPTH];

   // Synchronous write plus registered read; read-during-write returns old data.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/hmirror_line.sv
// Horizontal mirror stage. Every active line is stored into one of two line
// RAMs while the other RAM (holding the previous line) is read back from its
// last pixel to its first. In mirror mode the output therefore lags the input
// image by one line and the first line of each frame is black. In any other
// mode the block is a plain two-clock delay for sync, enable and pixels.
module hmirror_line
   import vpu_pkg::*;
#(
   parameter int MAX_WIDTH = 1920,
   parameter int ADDR_W    = 11
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       vs_i,
   input  logic       hs_i,
   input  logic       de_i,
   input  logic [7:0] rgb_r_i,
   input  logic [7:0] rgb_g_i,
   input  logic [7:0] rgb_b_i,
   input  logic [7:0] image_mode_i,
   output logic       vs_o,
   output logic       hs_o,
   output logic       de_o,
   output logic [7:0] rgb_r_o,
   output logic [7:0] rgb_g_o,
   output logic [7:0] rgb_b_o
);

   // One extra bit so a counter can hold MAX_WIDTH itself when it equals 2**ADDR_W.
   localparam int               CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WIDTH);

   sync_t             sync_d0;
   pixel_t            pix_d0;
   pixel_t            pix_in;
   pixel_t            pix_out;
   pixel_t            ram0_rd_data;
   pixel_t            ram1_rd_data;
   pixel_t            mirror_pix;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  rd_cnt_d;
   logic [CNT_W-1:0]  len_prev;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        mode_r;
   logic              bank;
   logic              rd_bank_d;
   logic              first_line;
   logic              first_line_d;
   logic              vs_rise;
   logic              de_fall;
   logic              wr_en;

   assign pix_in  = pack_rgb(rgb_r_i, rgb_g_i, rgb_b_i);
   assign vs_rise = vs_i & ~sync_d0.vs;
   assign de_fall = ~de_i & sync_d0.de;
   assign wr_en   = de_i && (wr_cnt < MAX_CNT);
   assign wr_addr = ADDR_W'(wr_cnt);
   // Walks the previous line backwards; once rd_cnt passes len_prev the
   // address wraps to junk, but the output mux blanks those pixels.
   assign rd_addr = ADDR_W'(len_prev - CNT_W'(1) - rd_cnt);

   line_ram_sdp #(
      .DEPTH  (MAX_WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram_bank0 (
      .clock   (clock),
      .wr_en   (wr_en & ~bank),
      .wr_addr (wr_addr),
      .wr_data (pix_in),
      .rd_addr (rd_addr),
      .rd_data (ram0_rd_data)
   );

   line_ram_sdp #(
      .DEPTH  (MAX_WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram_bank1 (
      .clock   (clock),
      .wr_en   (wr_en & bank),
      .wr_addr (wr_addr),
      .wr_data (pix_in),
      .rd_addr (rd_addr),
      .rd_data (ram1_rd_data)
   );

   // First pipeline stage: delays sync and bypass pixels alongside the RAM read,
   // and remembers which bank and read index that RAM read belongs to.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_d0      <= '0;
         pix_d0       <= '0;
         rd_cnt_d     <= '0;
         rd_bank_d    <= 1'b0;
         first_line_d <= 1'b0;
      end else begin
         sync_d0      <= '{vs: vs_i, hs: hs_i, de: de_i};
         pix_d0       <= pix_in;
         rd_cnt_d     <= rd_cnt;
         rd_bank_d    <= ~bank;
         first_line_d <= first_line;
      end
   end

   // Mode is sampled only at frame start so a frame is never half mirrored.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_r <= '0;
      end else if (vs_rise) begin
         mode_r <= image_mode_i;
      end
   end

   // Marks the first line of a frame; a frame start in the same clock as a
   // line end must win so the new frame's first line is still blanked.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         first_line <= 1'b1;
      end else if (vs_rise) begin
         first_line <= 1'b1;
      end else if (de_fall) begin
         first_line <= 1'b0;
      end
   end

   // Write side: fill the current bank, saturate on over-long lines, and at
   // line end hand the captured length over to the read side and swap banks.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_cnt   <= '0;
         len_prev <= '0;
         bank     <= 1'b0;
      end else if (de_fall) begin
         wr_cnt   <= '0;
         len_prev <= wr_cnt;
         bank     <= ~bank;
      end else if (wr_en) begin
         wr_cnt <= wr_cnt + CNT_W'(1);
      end
   end

   // Read side: count pixels of the current line, saturating so a long line
   // cannot wrap back into valid-looking indices.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt <= '0;
      end else if (de_fall) begin
         rd_cnt <= '0;
      end else if (de_i && (rd_cnt < MAX_CNT)) begin
         rd_cnt <= rd_cnt + CNT_W'(1);
      end
   end

   // Picks the mirrored pixel, blanking the frame's first line and any pixel
   // beyond the length of the previous line.
   always_comb begin
      mirror_pix = rd_bank_d ? ram1_rd_data : ram0_rd_data;
      if (first_line_d || (rd_cnt_d >= len_prev)) begin
         mirror_pix = '0;
      end
   end

   // Output stage: sync is always a straight delay; pixels come from the
   // mirror path (held between lines) or straight from the bypass pipe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vs_o    <= 1'b0;
         hs_o    <= 1'b0;
         de_o    <= 1'b0;
         pix_out <= '0;
      end else begin
         vs_o <= sync_d0.vs;
         hs_o <= sync_d0.hs;
         de_o <= sync_d0.de;
         if (mode_r == IMG_MODE_MIRROR) begin
            if (sync_d0.de) begin
               pix_out <= mirror_pix;
            end
         end else begin
            pix_out <= pix_d0;
         end
      end
   end

   assign rgb_r_o = pix_out[23:16];
   assign rgb_g_o = pix_out[15:8];
   assign rgb_b_o = pix_out[7:0];

endmodule
